mac8_dot_sched: RTL and testbench
=================================

# mac8_dot_sched

Job-level scheduler that shares one 4-lane packed-byte MAC datapath between `NUM_REQ` requesters. Each requester issues a dot-product job of `len` operand-word pairs. The scheduler grants jobs round-robin and streams the granted requester's operand words through the datapath, one per cycle. It sequences first-beat initialisation and accumulation itself, then returns the 32-bit result tagged with the job id. It sits between the issue-side accelerator ports and the shared MAC datapath, replacing per-port accumulator state.

## Interface
- `NUM_REQ`, default 2: number of requesters (≥2).
- `LEN_W`, default 8: width of the job length field (max `2^LEN_W-1` beats).
- `ID_W`, default 3: job id width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  abort the current job; no result is produced.
- `cmd_valid_i`  in  NUM_REQ  job request per requester.
- `cmd_ready_o`  out  NUM_REQ  job accepted (one-hot or zero).
- `cmd_len_i`  in  NUM_REQ×LEN_W  operand pairs in the job.
- `cmd_id_i`  in  NUM_REQ×ID_W  job tag.
- `op_valid_i`  in  NUM_REQ  operand pair valid.
- `op_ready_o`  out  NUM_REQ  operand pair consumed (one-hot or zero).
- `op_a_i`  in  NUM_REQ×32  four signed bytes.
- `op_b_i`  in  NUM_REQ×32  four unsigned bytes.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result consumer ready.
- `res_data_o`  out  32  dot-product result (two's complement).
- `res_id_o`  out  ID_W  id of the finished job.
- `res_src_o`  out  $clog2(NUM_REQ)  requester index of the finished job.
- `busy_o`  out  1  FSM is not IDLE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - Round-robin arbitration over `cmd_valid_i`, starting from priority pointer `rr_q`.
  - The winner receives `cmd_ready_o` combinationally in the same cycle; the scheduler latches `len`, `id` and `src`, and clears the beat counter.
  - `len≠0` → RUN. `len==0` → DONE with accumulator 0.
  - On grant, `rr_q` is set to winner+1, wrapping modulo `NUM_REQ`.
- **RUN:**
  - `op_ready_o[src]=1` every cycle; all other requesters see 0.
  - Each handshake (`op_valid_i[src] & op_ready_o[src]`) computes `beat = Σ_{i=0..3} sext(a.byte[i]) × zext(b.byte[i])`.
  - Each lane product is 16-bit signed and the lane sum is 18-bit signed, sign-extended to 32 bits.
  - First beat: `acc ← beat`. Later beats: `acc ← acc + beat`, wrapping modulo 2^32 with no saturation.
  - Handshake on beat `len` → DONE.
  - Bubbles (`op_valid_i` low) stall without side effects.
- **DONE:**
  - `res_valid_o=1`, `res_data_o=acc`, `res_id_o`/`res_src_o` come from latched values.
  - All outputs are held stable until `res_ready_i`, then → IDLE.
  - No `cmd_ready_o` is asserted in DONE.
- **Flush:**
  - In any state, `flush_i` forces the next state to IDLE, clears `acc` and the counter, and deasserts `res_valid_o`.
  - `rr_q` is kept.
  - A handshake in the flush cycle is not accumulated.
  - `flush_i` has priority over a simultaneous command grant; `cmd_ready_o` is 0 while `flush_i` is high.
- **Other requesters:** requesters that are not granted keep `cmd_valid_i` asserted. The scheduler holds no per-requester state except `rr_q`.

## Timing
- **Reset values:** FSM=IDLE, `acc`=0, counter=0, `rr_q`=0. All outputs are 0 except `cmd_ready_o`, which is combinational in IDLE.
- **Latency:** command accepted at cycle T; first operand at earliest T+1; last beat at T+len with no bubbles; `res_valid_o` at T+len+1.
- **Zero-length job:** `res_valid_o` at T+1 with data 0.
- **Throughput:** one operand pair per cycle in RUN. With `res_ready_i` tied high, the next command can be accepted at T+len+2.
- **Outputs:** all outputs are registered or decoded from registered state. The only combinational paths are `cmd_valid_i`→`cmd_ready_o` and the valid-independent `op_ready_o`.
- **Reset mid-job:** reset is asynchronous and returns all state to reset values immediately; the job is lost.

## Structure
- **Shared package (`mac8_pkg`):** `mac8_state_e` (IDLE/RUN/DONE), and the lane width constant `MAC8_LANES=4`.
- **Sub-module `mac8_lane_dp`:** purely combinational 4-lane signed×unsigned product plus sum, output 32-bit sign-extended.
  - The scheduler owns the accumulator register and the INIT/ACC select (first beat vs. subsequent beats).
- **Arbiter:** inline round-robin logic (priority rotate plus leading-one find).

## Test plan
- Req0 job `len=3`, `a=0x01020304`, `b=0x01010101` each beat, no bubbles → `res_data_o=0x0000001E`, `res_id_o`=cmd id, `res_valid_o` exactly 4 cycles after accept.
- Req1 job `len=2`, `a=0x80808080`, `b=0xFFFFFFFF` → each beat −130560; result `0xFFFC0400`.
- Both requesters hold `cmd_valid_i` continuously with `len=1` jobs → grants alternate 0,1,0,1; `res_src_o` alternates accordingly.
- `len=0` command → `res_valid_o` the next cycle with data `0x00000000`; hold `res_ready_i` low 5 cycles → outputs stable, no new grant.
- `flush_i` asserted on beat 2 of a `len=4` job → no result, `busy_o` low the next cycle; a following `len=1` job with `a=0x01020304`, `b=0x01010101` returns `0x0000000A` (no residue).
- Reset asserted mid-RUN with random bubbles on `op_valid_i` → all outputs 0 immediately, FSM IDLE, and a fresh job returns a correct result.

Source files
------------

// File: rtl/mac8_pkg.sv
// Shared types and constants for the packed-byte MAC scheduler.
package mac8_pkg;

    localparam int unsigned MAC8_LANES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } mac8_state_e;

endpackage

// File: rtl/mac8_lane_dp.sv
// Combinational 4-lane signed-byte x unsigned-byte product and lane sum,
// sign-extended to 32 bits.
module mac8_lane_dp
    import mac8_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] beat_o
);

    logic [17:0] a_x;
    logic [17:0] b_x;
    logic [17:0] prod_full;
    logic [17:0] sum;

    // The low 18 bits of the product of the sign-extended a and zero-extended b
    // are the exact two's-complement lane product; it always fits in 16 bits.
    always_comb begin
        a_x       = '0;
        b_x       = '0;
        prod_full = '0;
        sum       = '0;
        for (int i = 0; i < MAC8_LANES; i++) begin
            a_x       = {{10{a_i[8*i+7]}}, a_i[8*i +: 8]};
            b_x       = {10'd0, b_i[8*i +: 8]};
            prod_full = a_x * b_x;
            sum       = sum + {{2{prod_full[15]}}, prod_full[15:0]};
        end
        beat_o = {{14{sum[17]}}, sum};
    end

endmodule

// File: rtl/mac8_dot_sched.sv
// Round-robin job scheduler sharing one 4-lane packed-byte MAC datapath
// between NUM_REQ requesters; returns one tagged 32-bit dot product per job.
module mac8_dot_sched
    import mac8_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ID_W    = 3,
    localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       cmd_valid_i,
    output logic [NUM_REQ-1:0]       cmd_ready_o,
    input  logic [NUM_REQ*LEN_W-1:0] cmd_len_i,
    input  logic [NUM_REQ*ID_W-1:0]  cmd_id_i,
    input  logic [NUM_REQ-1:0]       op_valid_i,
    output logic [NUM_REQ-1:0]       op_ready_o,
    input  logic [NUM_REQ*32-1:0]    op_a_i,
    input  logic [NUM_REQ*32-1:0]    op_b_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [31:0]              res_data_o,
    output logic [ID_W-1:0]          res_id_o,
    output logic [SRC_W-1:0]         res_src_o,
    output logic                     busy_o
);

    mac8_state_e      state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [SRC_W-1:0] rr_q, rr_d;

    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W-1:0] rr_next;
    logic [LEN_W-1:0] win_len;
    logic [ID_W-1:0]  win_id;
    logic             op_valid_sel;
    logic [31:0]      op_a_sel;
    logic [31:0]      op_b_sel;
    logic [31:0]      beat;

    // Round-robin: scan from rr_q upward, then wrap around below rr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && cmd_valid_i[i] && (i >= int'(rr_q))) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && cmd_valid_i[i] && (i < int'(rr_q))) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(i);
            end
        end
        rr_next = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
    end

    always_comb begin
        win_len      = '0;
        win_id       = '0;
        op_valid_sel = 1'b0;
        op_a_sel     = '0;
        op_b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == win_idx) begin
                win_len = cmd_len_i[i*LEN_W +: LEN_W];
                win_id  = cmd_id_i[i*ID_W +: ID_W];
            end
            if (SRC_W'(i) == src_q) begin
                op_valid_sel = op_valid_i[i];
                op_a_sel     = op_a_i[32*i +: 32];
                op_b_sel     = op_b_i[32*i +: 32];
            end
        end
    end

    mac8_lane_dp u_lane_dp (
        .a_i    (op_a_sel),
        .b_i    (op_b_sel),
        .beat_o (beat)
    );

    always_comb begin
        cmd_ready_o = '0;
        op_ready_o  = '0;
        if (state_q == StIdle && !flush_i && win_found) begin
            cmd_ready_o[win_idx] = 1'b1;
        end
        if (state_q == StRun) begin
            op_ready_o[src_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        id_d    = id_q;
        src_d   = src_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    len_d   = win_len;
                    id_d    = win_id;
                    src_d   = win_idx;
                    cnt_d   = '0;
                    acc_d   = '0;
                    rr_d    = rr_next;
                    state_d = (win_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (op_valid_sel) begin
                    acc_d = (cnt_q == '0) ? beat : acc_q + beat;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over everything, including a grant in the same cycle.
        if (flush_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = len_q;
            id_d    = id_q;
            src_d   = src_q;
            rr_d    = rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign res_valid_o = (state_q == StDone);
    assign res_data_o  = acc_q;
    assign res_id_o    = id_q;
    assign res_src_o   = src_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mac8_dot_sched.sv
// Scoreboard bench for mac8_dot_sched: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_mac8_dot_sched;

    localparam int NR = 2;
    localparam int LW = 8;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic [NR-1:0]    cmd_valid = '0;
    logic [NR-1:0]    cmd_ready;
    logic [NR*LW-1:0] cmd_len = '0;
    logic [NR*IW-1:0] cmd_id = '0;
    logic [NR-1:0]    op_valid = '0;
    logic [NR-1:0]    op_ready;
    logic [NR*32-1:0] op_a = '0;
    logic [NR*32-1:0] op_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_data;
    logic [IW-1:0]    res_id;
    logic [0:0]       res_src;
    logic             busy;

    mac8_dot_sched #(
        .NUM_REQ (NR),
        .LEN_W   (LW),
        .ID_W    (IW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_len_i   (cmd_len),
        .cmd_id_i    (cmd_id),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_id_o    (res_id),
        .res_src_o   (res_src),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   data;
        logic [IW-1:0] id;
        int            src;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   rr_model = 0;
    int   ready_mode = 0;
    bit   started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, want, $time);
    endtask

    // Reference: sum of signed a-byte times unsigned b-byte over four lanes.
    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte sa;
        int  ub;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            ub = int'(b[8*i +: 8]);
            s  = s + int'(sa) * ub;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_ni && res_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_result: got data 0x%08h want no result", res_data);
            end else begin
                if (!started) begin
                    started = 1'b1;
                    if (exp_q[0].lat >= 0) chk("res_latency", cyc, exp_q[0].lat);
                end
                chk("res_data", res_data, exp_q[0].data);
                chk("res_id", 32'(res_id), 32'(exp_q[0].id));
                chk("res_src", 32'(res_src), exp_q[0].src);
                chk("no_grant_in_done", 32'(cmd_ready), 0);
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    started = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) res_ready = ($urandom % 2) == 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // abort_kind: 0 none, 1 flush on beat abort_at, 2 reset on beat abort_at.
    task automatic run_job(input int req, input int len, input logic [IW-1:0] id,
                           input bit fixed, input logic [31:0] fa, input logic [31:0] fb,
                           input bit bubbles, input int abort_kind, input int abort_at,
                           input bit has_c, input logic [31:0] cval);
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] want;
        bit          granted;
        int          c0;
        int          j;
        int          guard;
        want    = '0;
        granted = 1'b0;
        c0      = 0;
        j       = 0;
        guard   = 0;
        for (int i = 0; i < len; i++) begin
            av.push_back(fixed ? fa : $urandom);
            bv.push_back(fixed ? fb : $urandom);
            want = want + dot(av[i], bv[i]);
        end
        if (has_c) want = cval;
        cmd_valid[req]           = 1'b1;
        cmd_len[req*LW +: LW]    = len[LW-1:0];
        cmd_id[req*IW +: IW]     = id;
        for (int w = 0; w < 200 && !granted; w++) begin
            @(negedge clk);
            if (cmd_ready != '0) begin
                granted = 1'b1;
                c0      = cyc;
                chk("grant_onehot", 32'(cmd_ready), 32'(1) << req);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!granted) begin
            n_chk++;
            $display("FAIL grant_timeout: got no cmd_ready want grant to req %0d", req);
            cmd_valid[req] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid[req] = 1'b0;
        rr_model = (req + 1) % NR;
        if (abort_kind == 0)
            exp_q.push_back('{data: want, id: id, src: req, lat: bubbles ? -1 : c0 + len + 1});
        while (j < len && guard < 1000) begin
            guard++;
            if (abort_kind != 0 && j == abort_at) begin
                op_a[req*32 +: 32] = av[j];
                op_b[req*32 +: 32] = bv[j];
                if (abort_kind == 1) begin
                    op_valid[req] = 1'b1;
                    flush_i = 1'b1;
                    @(posedge clk);
                    #1;
                    flush_i = 1'b0;
                    op_valid[req] = 1'b0;
                    @(negedge clk);
                    chk("busy_after_flush", 32'(busy), 0);
                    chk("valid_after_flush", 32'(res_valid), 0);
                end else begin
                    op_valid[req] = ($urandom % 2) == 1;
                    rst_ni = 1'b0;
                    #1;
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_res_valid", 32'(res_valid), 0);
                    chk("rst_res_data", res_data, 0);
                    chk("rst_res_id", 32'(res_id), 0);
                    chk("rst_res_src", 32'(res_src), 0);
                    chk("rst_op_ready", 32'(op_ready), 0);
                    chk("rst_cmd_ready", 32'(cmd_ready), 0);
                    rr_model = 0;
                    op_valid[req] = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_ni = 1'b1;
                end
                @(posedge clk);
                #1;
                return;
            end
            op_valid[req] = bubbles ? (($urandom % 3) != 0) : 1'b1;
            op_a[req*32 +: 32] = av[j];
            op_b[req*32 +: 32] = bv[j];
            @(posedge clk);
            #1;
            if (op_valid[req]) j++;
        end
        op_valid[req] = 1'b0;
        if (j < len) begin
            n_chk++;
            $display("FAIL beat_timeout: got %0d beats want %0d", j, len);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 300 && !ok; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL idle_timeout: got %0d pending results want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] aa[NR];
        logic [31:0] bb[NR];
        int          ngrant;
        int          k;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_op_ready", 32'(op_ready), 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        run_job(0, 3, 3'd5, 1, 32'h01020304, 32'h01010101, 0, 0, 0, 1, 32'h0000001E);
        wait_idle();
        run_job(1, 2, 3'd2, 1, 32'h80808080, 32'hFFFFFFFF, 0, 0, 0, 1, 32'hFFFC0400);
        wait_idle();

        // Zero-length job with the consumer stalled; a competing request must wait.
        res_ready = 1'b0;
        run_job(0, 0, 3'd7, 0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
        cmd_valid[1]      = 1'b1;
        cmd_len[LW +: LW] = 8'd1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_no_grant", 32'(cmd_ready), 0);
            @(posedge clk);
            #1;
        end
        cmd_valid[1] = 1'b0;
        res_ready    = 1'b1;
        wait_idle();

        cmd_valid[0]     = 1'b1;
        cmd_len[0 +: LW] = 8'd1;
        flush_i          = 1'b1;
        @(negedge clk);
        chk("flush_blocks_grant", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        flush_i      = 1'b0;
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        run_job(0, 4, 3'd1, 1, 32'h01020304, 32'h01010101, 0, 1, 1, 0, 32'h0);
        run_job(0, 1, 3'd3, 1, 32'h01020304, 32'h01010101, 0, 0, 0, 1, 32'h0000000A);
        wait_idle();

        ready_mode = 1;
        repeat (20) begin
            run_job(int'($urandom % 2), int'($urandom % 7), 3'($urandom), 0, 32'h0, 32'h0,
                    ($urandom % 2) == 1, 0, 0, 0, 32'h0);
        end
        ready_mode = 0;
        res_ready  = 1'b1;
        wait_idle();

        run_job(1, 5, 3'd6, 0, 32'h0, 32'h0, 1, 2, 2, 0, 32'h0);
        run_job(1, 3, 3'd4, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        wait_idle();

        // Both requesters hold len=1 commands; grants must alternate.
        aa[0] = $urandom;
        aa[1] = $urandom;
        bb[0] = $urandom;
        bb[1] = $urandom;
        op_a      = {aa[1], aa[0]};
        op_b      = {bb[1], bb[0]};
        cmd_len   = {8'd1, 8'd1};
        cmd_id    = {3'd6, 3'd1};
        cmd_valid = 2'b11;
        op_valid  = 2'b11;
        ngrant    = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (cmd_ready != '0) begin
                chk("alt_grant", 32'(cmd_ready), 32'(1) << rr_model);
                k = cmd_ready[1] ? 1 : 0;
                exp_q.push_back('{data: dot(aa[k], bb[k]), id: (k == 1) ? 3'd6 : 3'd1,
                                  src: k, lat: cyc + 2});
                rr_model = (k + 1) % NR;
                ngrant++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = '0;
        wait_idle();
        op_valid = '0;
        chk("alt_grant_count", 32'(ngrant >= 4), 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
